// File: rtl/ser_pkg.sv
// ser_pkg: shared FSM state type and default word width for byte_serializer.
// PARITY exists only when SER_PARITY_EN is defined.
package ser_pkg;
   localparam int SER_WIDTH = 8;
`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} ser_state_t;
`else
   typedef enum logic [0:0] {IDLE, SHIFT} ser_state_t;
`endif
endpackage

// File: rtl/byte_serializer.sv
// byte_serializer: shifts a parallel word out one bit per accepted bit-FIFO write.
// Define SER_PARITY_EN to append an even-parity bit after the data bits.
module byte_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             full,
   output logic             wr_en,
   output logic             din,
   output logic             busy,
   output logic             word_done
);
   localparam int CW = $clog2(WIDTH + 1);
   ser_state_t state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic done_q, done_d;
   logic accept, xfer, last;
`ifdef SER_PARITY_EN
   logic par_q, par_d;
`endif
   assign accept = in_valid && state_q == IDLE;
   assign xfer   = state_q != IDLE && !full;
   assign last   = cnt_q == CW'(WIDTH - 1);

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      if (accept) state_d = SHIFT;
`ifdef SER_PARITY_EN
      else if (state_q == SHIFT && xfer && last) state_d = PARITY;
      else if (state_q == PARITY && xfer) state_d = IDLE;
`else
      else if (state_q == SHIFT && xfer && last) state_d = IDLE;
`endif
   end

   always_comb begin
      in_ready  = state_q == IDLE && !rst;
      wr_en     = state_q != IDLE;
      busy      = state_q != IDLE;
      word_done = done_q;
`ifdef SER_PARITY_EN
      din = state_q == PARITY ? par_q :
            state_q == SHIFT && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
`else
      din = state_q == SHIFT && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
`endif
   end

   // Datapath only advances on a real transfer, so back-pressure freezes everything.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (accept) begin
         sr_d  = in_data;
         cnt_d = '0;
      end else if (state_q == SHIFT && xfer) begin
         sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
         cnt_d = cnt_q + 1'b1;
      end
`ifdef SER_PARITY_EN
      par_d  = accept ? ^in_data : par_q;
      done_d = xfer && state_q == PARITY;
`else
      done_d = xfer && last;
`endif
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
`ifdef SER_PARITY_EN
         par_q  <= 1'b0;
`endif
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
`ifdef SER_PARITY_EN
         par_q  <= par_d;
`endif
      end
endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits (legal range 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 emitted first, 0 = bit 0 emitted first.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 full  input  1  downstream bit-FIFO full.
REQ-010 wr_en  output  1  bit write request to the downstream bit-FIFO.
REQ-011 din  output  1  serial bit presented with wr_en.
REQ-012 busy  output  1  word in progress.
REQ-013 word_done  output  1  one-cycle pulse when the last bit of a word is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and, when parity is compiled in, PARITY.
REQ-015 in_ready SHALL be 1 only in IDLE; a word SHALL be accepted at a rising edge where in_valid && in_ready.
REQ-016 On acceptance, SHALL capture in_data into a shift register, clear the bit counter and enter SHIFT.
REQ-017 wr_en SHALL be 1 in SHIFT and PARITY, otherwise 0; wr_en and din SHALL be driven only from registered state.
REQ-018 A bit is transferred at an edge where wr_en && !full; only then SHALL the shift register advance and the counter increment.
REQ-019 While full=1, wr_en, din and all state SHALL hold unchanged indefinitely.
REQ-020 din SHALL be the shift-register MSB when MSB_FIRST=1 and the LSB otherwise.
REQ-021 The first bit SHALL be presented in the cycle after acceptance; with full=0 throughout, WIDTH bits SHALL take WIDTH consecutive cycles.
REQ-022 On the WIDTH-th transfer (counter = WIDTH-1), SHALL go to PARITY if compiled in, else IDLE.
REQ-023 word_done SHALL pulse for exactly one cycle after the final transfer of a word (data bit or parity bit).
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 in_data and in_valid SHALL be ignored outside IDLE; a word is never lost or duplicated.
REQ-026 Minimum spacing between accepted words SHALL be WIDTH+1 cycles (WIDTH+2 with parity).
REQ-027 The counter SHALL be $clog2(WIDTH+1) bits and SHALL never wrap within a word.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, wr_en=0, din=0, busy=0, word_done=0, in_ready=0 while rst=1, and clear the counter and shift register.
REQ-029 Reset mid-word SHALL discard the partial word; no further bits of it are emitted.
REQ-030 in_ready SHALL become 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro SER_PARITY_EN, when defined, SHALL add state PARITY emitting one even-parity bit (XOR of all WIDTH data bits) after the data bits, subject to the same full back-pressure.
REQ-032 Without SER_PARITY_EN, no PARITY state or parity logic SHALL exist and each word is exactly WIDTH bits.

Structure
REQ-033 Package ser_pkg SHALL hold the FSM state typedef (ser_state_t) and the default WIDTH constant.
REQ-034 A single module SHALL suffice; no sub-module is required.

Verification
REQ-035 Reset, then accept 8'hA5 with MSB_FIRST=1 and full=0 -> din 1,0,1,0,0,1,0,1 on 8 consecutive wr_en cycles, word_done once, in_ready high again the following cycle.
REQ-036 MSB_FIRST=0, accept 8'h01 -> din sequence 1,0,0,0,0,0,0,0.
REQ-037 Accept 8'hF0, hold full=1 for 5 cycles after bit 3 -> wr_en/din frozen at bit 4 (value 0), then resume; exactly 8 transfers total.
REQ-038 Assert rst after 3 bits of 8'hFF -> wr_en drops immediately; after release, accept 8'h00 -> eight 0 bits only.
REQ-039 SER_PARITY_EN defined, accept 8'h07 -> 8 data bits then parity bit 1; accept 8'h03 -> parity bit 0.
REQ-040 in_valid held high with a new word each cycle -> words accepted only in IDLE, every 9 cycles (10 with parity), no drops.
